// File: rtl/clk_rst_seq_pkg.sv
// Shared types for the PLL reset sequencer: FSM state encoding and a saturating counter helper.
package clk_rst_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        PERIPH    = 3'd2,
        RUN       = 3'd3,
        SOFT      = 3'd4
    } seq_state_t;

    localparam int unsigned LOSS_W = 8;

    function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
        return (v == '1) ? v : v + LOSS_W'(1);
    endfunction

endpackage

// File: rtl/clk_rst_seq_sync_debounce.sv
// 2-FF synchronizer followed by a stable-count filter for a slow asynchronous level input.
module sync_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 5000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic             r_s1;
    logic             r_s2;
    logic             r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_done;

    assign w_diff = (r_s2 != r_q);
    assign w_done = w_diff && (r_cnt == CNT_W'(DEBOUNCE_CYC - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_q   <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            if (w_done) begin
                r_q   <= r_s2;
                r_cnt <= '0;
            end else if (w_diff) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // New level is presented in the cycle the hold count completes, not one cycle later.
    assign o_q = w_done ? r_s2 : r_q;

endmodule

// File: rtl/clk_rst_seq.sv
// PLL-lock driven reset sequencer: releases peripheral reset, then CPU reset, and re-asserts
// on lock loss, debounced button press or a CPU soft-reset request.
import clk_rst_seq_pkg::*;

module clk_rst_seq #(
    parameter int unsigned LOCK_STABLE_CYC = 1024,
    parameter int unsigned PERIPH_GAP_CYC  = 64,
    parameter int unsigned DEBOUNCE_CYC    = 5000,
    parameter int unsigned SOFT_RST_CYC    = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              btn_rst,
    input  logic              soft_rst_req,
    output logic              rst_periph,
    output logic              rst_cpu,
    output logic              seq_ready,
    output logic [LOSS_W-1:0] lock_loss_cnt
);

    seq_state_t        r_state, w_state_n;
    logic [CNT_W-1:0]  r_cnt, w_cnt_n;
    logic [LOSS_W-1:0] r_loss, w_loss_n;
    logic              r_lk_s1, r_lk_s2;
    logic              r_rst_periph, r_rst_cpu, r_ready;
    logic              w_lk, w_bt;

    sync_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .CNT_W       (CNT_W)
    ) u_btn_db (
        .i_clk(clk),
        .i_rst(rst),
        .i_d  (btn_rst),
        .o_q  (w_bt)
    );

    assign w_lk = r_lk_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lk_s1      <= 1'b0;
            r_lk_s2      <= 1'b0;
            r_state      <= WAIT_LOCK;
            r_cnt        <= '0;
            r_loss       <= '0;
            r_rst_periph <= 1'b1;
            r_rst_cpu    <= 1'b1;
            r_ready      <= 1'b0;
        end else begin
            r_lk_s1      <= pll_locked;
            r_lk_s2      <= r_lk_s1;
            r_state      <= w_state_n;
            r_cnt        <= w_cnt_n;
            r_loss       <= w_loss_n;
            r_rst_periph <= (w_state_n == WAIT_LOCK) || (w_state_n == STABLE);
            r_rst_cpu    <= (w_state_n != RUN);
            r_ready      <= (w_state_n == RUN);
        end
    end

    // Only WAIT_LOCK can be occupied with lk low, so lk==0 elsewhere is always a lock loss.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_loss_n  = r_loss;
        if ((r_state != WAIT_LOCK) && !w_lk) begin
            w_state_n = WAIT_LOCK;
            w_cnt_n   = '0;
            w_loss_n  = sat_inc(r_loss);
        end else if (w_bt) begin
            w_state_n = WAIT_LOCK;
            w_cnt_n   = '0;
        end else begin
            case (r_state)
                WAIT_LOCK: begin
                    w_cnt_n = '0;
                    if (w_lk) w_state_n = STABLE;
                end
                STABLE: begin
                    if (r_cnt == CNT_W'(LOCK_STABLE_CYC - 1)) begin
                        w_state_n = PERIPH;
                        w_cnt_n   = '0;
                    end else begin
                        w_cnt_n = r_cnt + CNT_W'(1);
                    end
                end
                PERIPH: begin
                    if (r_cnt == CNT_W'(PERIPH_GAP_CYC - 1)) begin
                        w_state_n = RUN;
                        w_cnt_n   = '0;
                    end else begin
                        w_cnt_n = r_cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (soft_rst_req) begin
                        w_state_n = SOFT;
                        w_cnt_n   = '0;
                    end
                end
                SOFT: begin
                    if (r_cnt == CNT_W'(SOFT_RST_CYC - 1)) begin
                        w_state_n = RUN;
                        w_cnt_n   = '0;
                    end else begin
                        w_cnt_n = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_n = WAIT_LOCK;
                    w_cnt_n   = '0;
                end
            endcase
        end
    end

    assign rst_periph    = r_rst_periph;
    assign rst_cpu       = r_rst_cpu;
    assign seq_ready     = r_ready;
    assign lock_loss_cnt = r_loss;

endmodule
